// File: rtl/pd_main.sv
// pd_main: Mueller-Muller phase detector over time-interleaved ADC slices with decimated, saturated output.
// Ports:
//   clk       - parallel data clock, all state changes on the rising edge
//   rst       - synchronous active-high reset (priority over enable)
//   enable    - PD enable; low clears pipeline, window and history, holds pd_out
//   din       - Nti signed ADC samples per word, din[0] earliest in time
//   pd_offset - signed phase-offset code added to every slice error
//   pd_out    - decimated, saturated phase-error sum (held between strobes)
//   pd_valid  - one-cycle strobe marking a new pd_out
//   pd_sat    - high with pd_valid when pd_out was clipped
module pd_main #(
    parameter int Nadc = 8,
    parameter int Nti  = 2,
    parameter int Ndec = 2,
    parameter int Nout = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic signed [Nadc-1:0] din [Nti],
    input  logic signed [Nadc-1:0] pd_offset,
    output logic signed [Nout-1:0] pd_out,
    output logic                   pd_valid,
    output logic                   pd_sat
);
    localparam int EW = Nadc + 2;
    localparam int WW = EW + $clog2(Nti);
    localparam int AW = WW + Ndec;
    localparam int DW = Ndec > 0 ? Ndec : 1;
    localparam int SW = (AW > Nout ? AW : Nout) + 1;
    localparam logic signed [SW-1:0] HI = {{(SW-Nout+1){1'b0}}, {(Nout-1){1'b1}}};
    localparam logic signed [SW-1:0] LO = {{(SW-Nout+1){1'b1}}, {(Nout-1){1'b0}}};
    localparam logic [DW-1:0] DLAST = DW'((2 ** Ndec) - 1);

    logic signed [Nadc-1:0] h_x;
    logic                   h_ok;
    logic signed [Nadc-1:0] px [Nti];
    logic                   pok [Nti];
    logic signed [EW-1:0]   e [Nti];
    logic signed [EW-1:0]   e_r [Nti];
    logic                   v1, v2;
    logic signed [WW-1:0]   w, w_r;
    logic [DW-1:0]          dcnt;
    logic signed [AW-1:0]   acc, acc_next;
    logic signed [SW-1:0]   acc_ext;
    logic                   clip;
    logic signed [Nout-1:0] sat_val;

    // Previous-sample view per slice: slice 0 looks back into the history
    // register, whose cleared state (h_ok=0, x=0) makes both MM terms vanish.
    always_comb begin
        px[0] = h_x;
        pok[0] = h_ok;
        for (int k = 1; k < Nti; k++) begin
            px[k] = din[k-1];
            pok[k] = 1'b1;
        end
        w = '0;
        for (int k = 0; k < Nti; k++) begin
            e[k] = (pok[k] ? (px[k][Nadc-1] ? -EW'(din[k]) : EW'(din[k])) : EW'(0))
                 - (din[k][Nadc-1] ? -EW'(px[k]) : EW'(px[k]))
                 + EW'(pd_offset);
            w = w + WW'(e_r[k]);
        end
    end

    // Accumulator is sized for a full window, so only the final output clips.
    assign acc_next = acc + AW'(w_r);
    assign acc_ext  = SW'(acc_next);
    assign clip     = (acc_ext > HI) || (acc_ext < LO);
    assign sat_val  = acc_ext > HI ? Nout'(HI) : acc_ext < LO ? Nout'(LO) : Nout'(acc_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            dcnt     <= '0;
            acc      <= '0;
            h_x      <= '0;
            h_ok     <= 1'b0;
            pd_out   <= '0;
            pd_valid <= 1'b0;
            pd_sat   <= 1'b0;
        end else if (!enable) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            dcnt     <= '0;
            acc      <= '0;
            h_x      <= '0;
            h_ok     <= 1'b0;
            pd_valid <= 1'b0;
            pd_sat   <= 1'b0;
        end else begin
            e_r      <= e;
            v1       <= 1'b1;
            h_x      <= din[Nti-1];
            h_ok     <= 1'b1;
            w_r      <= w;
            v2       <= v1;
            pd_valid <= 1'b0;
            pd_sat   <= 1'b0;
            if (v2) begin
                if (dcnt == DLAST) begin
                    pd_out   <= sat_val;
                    pd_sat   <= clip;
                    pd_valid <= 1'b1;
                    acc      <= '0;
                    dcnt     <= '0;
                end else begin
                    acc  <= acc_next;
                    dcnt <= dcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pd_main.sv
// tb_pd_main: directed and randomized checks of pd_main against a sample-stream reference model.
module tb_pd_main;
    localparam int WIN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic signed [7:0] din [2];
    logic signed [7:0] pd_offset;
    logic signed [9:0] pd_out;
    logic              pd_valid;
    logic              pd_sat;

    int checks = 0;
    int passed = 0;
    int cyc_n  = 0;

    int prev_x;
    bit prev_ok;
    int win_sum;
    int win_cnt;
    int due_q[$];
    int val_q[$];
    int exp_out;
    int exp_valid;
    int exp_sat;

    always #5 clk = ~clk;

    pd_main #(.Nadc(8), .Nti(2), .Ndec(2), .Nout(10)) dut (
        .clk(clk), .rst(rst), .enable(enable), .din(din),
        .pd_offset(pd_offset), .pd_out(pd_out), .pd_valid(pd_valid), .pd_sat(pd_sat)
    );

    function automatic int sgn(input int x);
        return x >= 0 ? 1 : -1;
    endfunction

    function automatic int clip10(input int v);
        return v > 511 ? 511 : v < -512 ? -512 : v;
    endfunction

    task automatic check(input string tag, input int obs, input int req);
        checks++;
        assert (obs === req) passed++;
        else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc_n, obs, req);
    endtask

    // One clock: drive inputs, advance the reference model, sample after the edge.
    task automatic step(input bit r, input bit en, input int d0, input int d1, input int off);
        int xs[2];
        int w, pa, px, v;
        @(negedge clk);
        rst = r;
        enable = en;
        din[0] = 8'(d0);
        din[1] = 8'(d1);
        pd_offset = 8'(off);
        cyc_n++;
        exp_valid = 0;
        exp_sat = 0;
        if (r || !en) begin
            prev_x = 0;
            prev_ok = 0;
            win_sum = 0;
            win_cnt = 0;
            due_q.delete();
            val_q.delete();
            if (r) exp_out = 0;
        end else begin
            xs[0] = d0;
            xs[1] = d1;
            w = 0;
            px = prev_x;
            pa = prev_ok ? sgn(prev_x) : 0;
            for (int k = 0; k < 2; k++) begin
                w += pa * xs[k] - sgn(xs[k]) * px + off;
                pa = sgn(xs[k]);
                px = xs[k];
            end
            prev_x = d1;
            prev_ok = 1;
            win_sum += w;
            win_cnt++;
            if (win_cnt == WIN) begin
                due_q.push_back(cyc_n + 2);
                val_q.push_back(win_sum);
                win_sum = 0;
                win_cnt = 0;
            end
            if (due_q.size() > 0 && due_q[0] == cyc_n) begin
                v = val_q.pop_front();
                void'(due_q.pop_front());
                exp_valid = 1;
                exp_out = clip10(v);
                exp_sat = (clip10(v) != v) ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
        check("pd_valid", int'(pd_valid), exp_valid);
        check("pd_sat", int'(pd_sat), exp_sat);
        check("pd_out", int'(pd_out), exp_out);
    endtask

    initial begin
        int d0, d1, off;
        bit r, en;
        rst = 1'b1;
        enable = 1'b0;
        din[0] = '0;
        din[1] = '0;
        pd_offset = '0;
        exp_out = 0;
        step(1, 0, 0, 0, 0);
        step(1, 1, 5, 5, 5);
        check("reset_out", int'(pd_out), 0);

        for (int i = 0; i < 12; i++) step(0, 1, 10, 10, 0);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 5);
        check("offset5_valid", int'(pd_valid), 1);
        check("offset5_out", int'(pd_out), 40);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 127);
        check("offset127_out", int'(pd_out), 511);
        check("offset127_sat", int'(pd_sat), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 127);
        check("offset127_sat2", int'(pd_sat), 1);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) step(0, 1, 30, -10, 0);
        check("mm_first_out", int'(pd_out), 20);
        for (int i = 0; i < 4; i++) step(0, 1, 30, -10, 0);
        check("mm_next_out", int'(pd_out), 0);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 3);
        step(0, 1, 0, 0, 3);
        step(0, 1, 0, 0, 3);
        step(0, 0, 0, 0, 3);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, -7);
        check("drop_no_strobe_yet", int'(pd_valid), 0);
        check("drop_hold_out", int'(pd_out), 24);
        step(0, 1, 0, 0, -7);
        check("drop_strobe", int'(pd_valid), 1);
        check("drop_out", int'(pd_out), -56);

        step(0, 1, 40, -40, 0);
        step(0, 1, 40, -40, 0);
        step(1, 1, 40, -40, 0);
        check("rst_mid_out", int'(pd_out), 0);
        check("rst_mid_valid", int'(pd_valid), 0);
        for (int i = 0; i < 6; i++) step(0, 1, -128, 127, -128);
        check("rst_next_strobe", int'(pd_valid), 1);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(99) < 2;
            en = $urandom_range(99) < 92;
            d0 = int'($urandom_range(255)) - 128;
            d1 = int'($urandom_range(255)) - 128;
            off = ($urandom_range(3) == 0) ? int'($urandom_range(255)) - 128
                                           : int'($urandom_range(16)) - 8;
            step(r, en, d0, d1, off);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
